// File: rtl/main_mem_responder.sv
// Memory-side responder for cache line fills and write-backs.
// Serves one 128-bit line per request from an internal array, completing
// after LATENCY cycles with a one-cycle ready pulse, and counts completed
// reads and writes.
module main_mem_responder #(
  parameter int unsigned LATENCY   = 4,
  parameter int unsigned MEM_LINES = 1024,
  localparam int unsigned IW       = $clog2(MEM_LINES)
) (
  input  logic         clk_i,
  input  logic         rst_ni,
  input  logic [31:0]  mem_req_addr_i,
  input  logic [127:0] mem_req_data_i,
  input  logic         mem_req_rw_i,
  input  logic         mem_req_valid_i,
  output logic [127:0] mem_data_o,
  output logic         mem_ready_o,
  output logic         busy_o,
  output logic [31:0]  rd_cnt_o,
  output logic [31:0]  wr_cnt_o
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_BUSY,
    S_RESP
  } state_e;

  localparam logic [7:0] LAT_LOAD = 8'(LATENCY - 1);

  state_e         state_q, state_d;
  logic [7:0]     lat_q, lat_d;
  logic [IW-1:0]  idx_q;
  logic [127:0]   data_q;
  logic           rw_q;
  logic           capture;
  logic           commit;

  logic [IW-1:0]  c_idx;
  logic [127:0]   c_data;
  logic           c_rw;

  logic [127:0]   mem_q [MEM_LINES];

  // Offset bits and bits above the line index play no part; lines alias.
  logic unused_addr_bits;
  assign unused_addr_bits = ^{mem_req_addr_i[31:IW+4], mem_req_addr_i[3:0]};

  // Next-state and latency-counter logic.
  always_comb begin
    // NOTE: every variable gets a default first so no latch is inferred.
    state_d = state_q;
    lat_d   = lat_q;
    capture = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (mem_req_valid_i) begin
          capture = 1'b1;
          lat_d   = LAT_LOAD;
          state_d = (LATENCY == 1) ? S_RESP : S_BUSY;
        end
      end
      S_BUSY: begin
        // The counter reaches zero on the same edge that enters RESP.
        lat_d = lat_q - 8'd1;
        if (lat_q == 8'd1) state_d = S_RESP;
      end
      S_RESP:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Commit happens on the edge entering RESP. With LATENCY=1 that is the
  // acceptance edge itself, so the live request is used instead of the
  // capture registers, which are only loaded on that same edge.
  always_comb begin
    commit = (state_d == S_RESP);
    if (state_q == S_IDLE) begin
      c_idx  = mem_req_addr_i[IW+3:4];
      c_data = mem_req_data_i;
      c_rw   = mem_req_rw_i;
    end else begin
      c_idx  = idx_q;
      c_data = data_q;
      c_rw   = rw_q;
    end
  end

  // State, request capture, registered outputs and transaction counters.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q     <= S_IDLE;
      lat_q       <= 8'd0;
      idx_q       <= '0;
      data_q      <= '0;
      rw_q        <= 1'b0;
      mem_data_o  <= '0;
      mem_ready_o <= 1'b0;
      busy_o      <= 1'b0;
      rd_cnt_o    <= '0;
      wr_cnt_o    <= '0;
    end else begin
      // NOTE: sequential state uses non-blocking assignments only.
      state_q     <= state_d;
      lat_q       <= lat_d;
      mem_ready_o <= (state_d == S_RESP);
      busy_o      <= (state_d != S_IDLE);
      if (capture) begin
        idx_q  <= mem_req_addr_i[IW+3:4];
        data_q <= mem_req_data_i;
        rw_q   <= mem_req_rw_i;
      end
      if (commit) begin
        if (c_rw) begin
          wr_cnt_o <= wr_cnt_o + 32'd1;
        end else begin
          mem_data_o <= mem_q[c_idx];
          rd_cnt_o   <= rd_cnt_o + 32'd1;
        end
      end
    end
  end

  // Line array write port.
  always_ff @(posedge clk_i) begin
    // NOTE: the array has no reset; contents survive rst_ni and an aborted
    // write never reaches it because commit needs the RESP transition.
    if (commit && c_rw) mem_q[c_idx] <= c_data;
  end

endmodule

// File: tb/tb_main_mem_responder.sv
// Self-checking bench for main_mem_responder: table-driven single
// transactions plus hand-written sequences for reset abort, back-to-back
// requests, held valid with counter wrap, and LATENCY=1 aliasing.
module tb_main_mem_responder;

  logic         clk = 1'b0;
  logic         rst_n = 1'b1;

  logic [31:0]  addr = '0;
  logic [127:0] wdata = '0;
  logic         rw = 1'b0;
  logic         valid = 1'b0;
  logic [127:0] mem_data;
  logic         ready, busy;
  logic [31:0]  rd_cnt, wr_cnt;

  logic [31:0]  l1_addr = '0;
  logic [127:0] l1_wdata = '0;
  logic         l1_rw = 1'b0;
  logic         l1_valid = 1'b0;
  logic [127:0] l1_mem_data;
  logic         l1_ready, l1_busy;
  logic [31:0]  l1_rd_cnt, l1_wr_cnt;

  int total = 0;
  int bad = 0;

  localparam logic [127:0] D_P   = 128'h5555_0000_1111_2222_3333_4444_5555_6666;
  localparam logic [127:0] D_A5  = {16{8'hA5}};
  localparam logic [127:0] D_L20 = 128'h2020_2020_0BAD_F00D_2020_2020_CAFE_0020;
  localparam logic [127:0] D_Q   = 128'hDEAD_BEEF_DEAD_BEEF_DEAD_BEEF_DEAD_BEEF;
  localparam logic [127:0] D_W40 = 128'h1234_5678_9ABC_DEF0_0FED_CBA9_8765_4321;
  localparam logic [127:0] D_WB  = 128'h0100_0100_0100_0100_0100_0100_0100_0100;
  localparam logic [127:0] D_AL  = 128'hAA55_AA55_1357_9BDF_2468_ACE0_FFFF_0001;

  main_mem_responder #(.LATENCY(4), .MEM_LINES(1024)) dut (
    .clk_i          (clk),
    .rst_ni         (rst_n),
    .mem_req_addr_i (addr),
    .mem_req_data_i (wdata),
    .mem_req_rw_i   (rw),
    .mem_req_valid_i(valid),
    .mem_data_o     (mem_data),
    .mem_ready_o    (ready),
    .busy_o         (busy),
    .rd_cnt_o       (rd_cnt),
    .wr_cnt_o       (wr_cnt)
  );

  main_mem_responder #(.LATENCY(1), .MEM_LINES(1024)) u_lat1 (
    .clk_i          (clk),
    .rst_ni         (rst_n),
    .mem_req_addr_i (l1_addr),
    .mem_req_data_i (l1_wdata),
    .mem_req_rw_i   (l1_rw),
    .mem_req_valid_i(l1_valid),
    .mem_data_o     (l1_mem_data),
    .mem_ready_o    (l1_ready),
    .busy_o         (l1_busy),
    .rd_cnt_o       (l1_rd_cnt),
    .wr_cnt_o       (l1_wr_cnt)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic         rw;
    logic [31:0]  addr;
    logic [127:0] wdata;
    logic [127:0] exp_data;
    logic [31:0]  exp_rd;
    logic [31:0]  exp_wr;
  } vec_t;

  vec_t vecs [8];

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // One request held valid for a single cycle; ready must follow 4 cycles
  // after acceptance with the expected data and counters.
  task automatic run_vec(input int i);
    int lat;
    bit seen;
    @(negedge clk);
    rw    = vecs[i].rw;
    addr  = vecs[i].addr;
    wdata = vecs[i].wdata;
    valid = 1'b1;
    @(negedge clk);
    valid = 1'b0;
    lat   = 0;
    seen  = 1'b0;
    for (int k = 1; k <= 20; k++) begin
      if (ready) begin
        seen = 1'b1;
        lat  = k;
        break;
      end
      @(negedge clk);
    end
    if (!seen) begin
      check($sformatf("vec%0d ready timeout", i), 128'd0, 128'd1);
    end else begin
      check($sformatf("vec%0d latency", i), 128'(lat), 128'd4);
      check($sformatf("vec%0d busy at ready", i), 128'(busy), 128'd1);
      check($sformatf("vec%0d data", i), mem_data, vecs[i].exp_data);
      check($sformatf("vec%0d rd_cnt", i), 128'(rd_cnt), 128'(vecs[i].exp_rd));
      check($sformatf("vec%0d wr_cnt", i), 128'(wr_cnt), 128'(vecs[i].exp_wr));
      @(negedge clk);
      check($sformatf("vec%0d ready pulse width", i), 128'(ready), 128'd0);
      check($sformatf("vec%0d busy after", i), 128'(busy), 128'd0);
    end
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, " ready"}, 128'(ready), 128'd0);
    check({tag, " busy"}, 128'(busy), 128'd0);
    check({tag, " data"}, mem_data, 128'd0);
    check({tag, " rd_cnt"}, 128'(rd_cnt), 128'd0);
    check({tag, " wr_cnt"}, 128'(wr_cnt), 128'd0);
  endtask

  initial begin
    int first, second, pulses;

    // Phase A: preloads and one read before the aborted write.
    vecs[0] = '{1'b1, 32'h0000_0050, D_P,   128'd0, 32'd0, 32'd1};
    vecs[1] = '{1'b1, 32'h0000_0030, D_A5,  128'd0, 32'd0, 32'd2};
    vecs[2] = '{1'b1, 32'h0000_0200, D_L20, 128'd0, 32'd0, 32'd3};
    vecs[3] = '{1'b0, 32'h0000_0030, '0,    D_A5,   32'd1, 32'd3};
    // Phase B: after the reset abort, counters restart from zero.
    vecs[4] = '{1'b0, 32'h0000_0030, '0,    D_A5,   32'd1, 32'd0};
    vecs[5] = '{1'b1, 32'h0000_0040, D_W40, D_A5,   32'd1, 32'd1};
    vecs[6] = '{1'b0, 32'h0000_0040, '0,    D_W40,  32'd2, 32'd1};
    vecs[7] = '{1'b0, 32'h0000_0050, '0,    D_P,    32'd3, 32'd1};

    #1 rst_n = 1'b0;
    #2 check_all_zero("reset");
    check("l1 reset ready", 128'(l1_ready), 128'd0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < 4; i++) run_vec(i);

    // Reset in the middle of a write to line 5: outputs clear at once and
    // the write never lands.
    @(negedge clk);
    rw = 1'b1; addr = 32'h0000_0050; wdata = D_Q; valid = 1'b1;
    @(negedge clk);
    valid = 1'b0;
    @(negedge clk);
    check("abort busy before reset", 128'(busy), 128'd1);
    #2 rst_n = 1'b0;
    #1 check_all_zero("abort");
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;

    for (int i = 4; i < 8; i++) run_vec(i);

    // Write-back then allocate with valid held across ready.
    @(negedge clk);
    rw = 1'b1; addr = 32'h0000_0100; wdata = D_WB; valid = 1'b1;
    first = 0; second = 0;
    for (int k = 1; k <= 20; k++) begin
      @(negedge clk);
      if (ready) begin
        if (first == 0) begin
          first = k;
          check("wb wr_cnt at first ready", 128'(wr_cnt), 128'd2);
          rw = 1'b0; addr = 32'h0000_0200; wdata = D_AL;
        end else begin
          second = k;
          check("alloc data", mem_data, D_L20);
          check("alloc rd_cnt", 128'(rd_cnt), 128'd4);
          valid = 1'b0;
          break;
        end
      end
    end
    valid = 1'b0;
    check("wb first ready cycle", 128'(first), 128'd4);
    check("wb ready spacing", 128'(second - first), 128'd5);

    // Counter wrap with a read held valid for 10 cycles.
    @(negedge clk);
    @(negedge clk);
    force dut.rd_cnt_o = 32'hFFFF_FFFF;
    #1 release dut.rd_cnt_o;
    #1 check("wrap preset", 128'(rd_cnt), 128'hFFFF_FFFF);
    @(negedge clk);
    rw = 1'b0; addr = 32'h0000_0030; valid = 1'b1;
    pulses = 0;
    for (int k = 1; k <= 10; k++) begin
      @(negedge clk);
      if (k == 10) valid = 1'b0;
      if (ready) pulses++;
      if (k == 4) begin
        check("held ready at 4", 128'(ready), 128'd1);
        check("held rd_cnt wrap", 128'(rd_cnt), 128'd0);
      end
      if (k == 9) begin
        check("held ready at 9", 128'(ready), 128'd1);
        check("held rd_cnt after wrap", 128'(rd_cnt), 128'd1);
        check("held data", mem_data, D_A5);
      end
    end
    check("held pulse count", 128'(pulses), 128'd2);
    @(negedge clk);
    @(negedge clk);
    check("held idle after drop", 128'(busy), 128'd0);

    // LATENCY=1 instance: write 0x10, read aliased 0x0001_0010.
    @(negedge clk);
    l1_rw = 1'b1; l1_addr = 32'h0000_0010; l1_wdata = D_W40 ^ D_A5; l1_valid = 1'b1;
    @(negedge clk);
    l1_valid = 1'b0;
    check("l1 write ready", 128'(l1_ready), 128'd1);
    check("l1 write busy", 128'(l1_busy), 128'd1);
    check("l1 wr_cnt", 128'(l1_wr_cnt), 128'd1);
    check("l1 data unchanged by write", l1_mem_data, 128'd0);
    @(negedge clk);
    check("l1 write ready width", 128'(l1_ready), 128'd0);
    l1_rw = 1'b0; l1_addr = 32'h0001_0010; l1_valid = 1'b1;
    @(negedge clk);
    l1_valid = 1'b0;
    check("l1 read ready", 128'(l1_ready), 128'd1);
    check("l1 alias data", l1_mem_data, D_W40 ^ D_A5);
    check("l1 rd_cnt", 128'(l1_rd_cnt), 128'd1);
    @(negedge clk);
    check("l1 read ready width", 128'(l1_ready), 128'd0);
    check("l1 busy after", 128'(l1_busy), 128'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
